kd_poly_loader: RTL and testbench

Upstream feeder for the unified Kyber/Dilithium NTT core. It accepts a stream of 24-bit polynomial words over a valid/ready handshake and range-reduces each coefficient into [0, q). It scatters the words across the core's four coefficient banks (bank_0..bank_3) and then issues a one-cycle start pulse to the core. It replaces preloading the banks from files, and holds off new loads until the core reports completion.

---
 rtl/kd_pkg.sv | 40 ++++
 rtl/kd_cond_sub.sv | 64 ++++++
 rtl/kd_poly_loader.sv | 167 ++++++++++++++++
 tb/tb_kd_poly_loader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// -----------------------------------------------------------------------------
// kd_pkg
// Shared definitions for the Kyber/Dilithium polynomial loader:
//   - modulus constants for both schemes
//   - scheme/mode enum and per-mode word counts
//   - loader FSM state enum
//   - small helpers used by the loader datapath
// No ports (package).
// -----------------------------------------------------------------------------
package kd_pkg;

  localparam int unsigned KYBER_Q     = 3329;
  localparam int unsigned DILITHIUM_Q = 8380417;

  typedef enum logic {
    KYBER     = 1'b0,
    DILITHIUM = 1'b1
  } kd_mode_e;

  // Words per polynomial load: Kyber packs two coefficients per word.
  localparam logic [8:0] KYBER_WORDS     = 9'd128;
  localparam logic [8:0] DILITHIUM_WORDS = 9'd256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } kd_state_e;

  function automatic logic [8:0] words_for(input kd_mode_e mode);
    return (mode == DILITHIUM) ? DILITHIUM_WORDS : KYBER_WORDS;
  endfunction

  function automatic logic [3:0] bank_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/kd_cond_sub.sv
// -----------------------------------------------------------------------------
// kd_cond_sub
// Combinational, mode-aware conditional subtractor. One subtraction per
// coefficient is exact for the input ranges involved (12-bit Kyber halves,
// 23-bit Dilithium coefficient), so no iteration is needed.
//
// Ports:
//   i_kd_mode  in   mode select (KYBER: two 12-bit halves, DILITHIUM: [22:0])
//   i_word     in   raw input word
//   o_word     out  reduced word (Dilithium bit [23] forced to 0)
//   o_reduced  out  1 if any coefficient in the word was >= q
// -----------------------------------------------------------------------------
module kd_cond_sub
  import kd_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned KQ     = KYBER_Q,
  parameter int unsigned DQ     = DILITHIUM_Q
) (
  input  kd_mode_e           i_kd_mode,
  input  logic [DATA_W-1:0]  i_word,
  output logic [DATA_W-1:0]  o_word,
  output logic               o_reduced
);

  localparam logic [11:0] W_KQ = 12'(KQ);
  localparam logic [22:0] W_DQ = 23'(DQ);

  logic [11:0] w_lo;
  logic [11:0] w_hi;
  logic [22:0] w_dl;
  logic        w_lo_ge;
  logic        w_hi_ge;
  logic        w_dl_ge;
  logic [11:0] w_lo_red;
  logic [11:0] w_hi_red;
  logic [22:0] w_dl_red;

  assign w_lo = i_word[11:0];
  assign w_hi = i_word[23:12];
  assign w_dl = i_word[22:0];   // bit [23] is not part of a Dilithium coefficient

  assign w_lo_ge = (w_lo >= W_KQ);
  assign w_hi_ge = (w_hi >= W_KQ);
  assign w_dl_ge = (w_dl >= W_DQ);

  assign w_lo_red = w_lo_ge ? (w_lo - W_KQ) : w_lo;
  assign w_hi_red = w_hi_ge ? (w_hi - W_KQ) : w_hi;
  assign w_dl_red = w_dl_ge ? (w_dl - W_DQ) : w_dl;

  always_comb begin
    o_word    = '0;
    o_reduced = 1'b0;
    if (i_kd_mode == KYBER) begin
      o_word[11:0]  = w_lo_red;
      o_word[23:12] = w_hi_red;
      o_reduced     = w_lo_ge | w_hi_ge;
    end else begin
      o_word[22:0]  = w_dl_red;
      o_reduced     = w_dl_ge;
    end
  end

endmodule

// File: rtl/kd_poly_loader.sv
// -----------------------------------------------------------------------------
// kd_poly_loader
// Streams a polynomial into the NTT core's four coefficient banks, reducing
// each coefficient into [0, q), then pulses the core's start and waits for
// its completion before accepting another load.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst          in   asynchronous active-low reset
//   cfg_start    in   begin a load (only honoured in IDLE)
//   cfg_kd_mode  in   0 = Kyber, 1 = Dilithium; sampled with cfg_start
//   s_valid      in   input word valid
//   s_ready      out  loader accepts a word this cycle
//   s_data       in   input word
//   bank_we      out  one-hot bank write enable (registered)
//   bank_addr    out  write address within the selected bank (registered)
//   bank_wdata   out  reduced word (registered)
//   ntt_start    out  one-cycle start pulse to the core
//   ntt_kd_mode  out  mode latched at cfg_start
//   ntt_done     in   completion pulse from the core (only honoured in WAIT)
//   busy         out  high outside IDLE
//   reduced_flag out  sticky: some coefficient of this load needed reduction
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for cfg_start
// ST_LOAD  | accepting words, writing word k to bank k[1:0], addr k>>2
// ST_FLUSH | last registered write is on the bank port
// ST_START | ntt_start asserted for this single cycle
// ST_WAIT  | core running; leave on ntt_done
// -----------------------------------------------------------------------------
module kd_poly_loader
  import kd_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned KQ     = KYBER_Q,
  parameter int unsigned DQ     = DILITHIUM_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_kd_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [3:0]        bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  output logic              ntt_start,
  output logic              ntt_kd_mode,
  input  logic              ntt_done,
  output logic              busy,
  output logic              reduced_flag
);

  kd_state_e         r_state;
  kd_state_e         w_next;
  kd_mode_e          r_mode;
  logic [7:0]        r_cnt;
  logic              r_red;
  logic [3:0]        r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_cfg_go;
  logic              w_accept;
  logic              w_last;
  logic [DATA_W-1:0] w_sub_word;
  logic              w_sub_red;

  kd_cond_sub #(
    .DATA_W (DATA_W),
    .KQ     (KQ),
    .DQ     (DQ)
  ) u_cond_sub (
    .i_kd_mode (r_mode),
    .i_word    (s_data),
    .o_word    (w_sub_word),
    .o_reduced (w_sub_red)
  );

  assign w_cfg_go = (r_state == ST_IDLE) & cfg_start;
  assign w_accept = (r_state == ST_LOAD) & s_valid;
  assign w_last   = ({1'b0, r_cnt} == (words_for(r_mode) - 9'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mode  <= KYBER;
      r_cnt   <= 8'd0;
      r_red   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_cfg_go) begin
        r_mode <= kd_mode_e'(cfg_kd_mode);
        r_cnt  <= 8'd0;
        r_red  <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_sub_red) begin
          r_red <= 1'b1;
        end
      end
    end
  end

  // Bank write port: one registered stage after acceptance. Address and data
  // hold between writes; only the enable returns to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 4'b0000;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept ? bank_onehot(r_cnt[1:0]) : 4'b0000;
      if (w_accept) begin
        r_addr  <= ADDR_W'(r_cnt[7:2]);
        r_wdata <= w_sub_word;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    s_ready   = 1'b0;
    ntt_start = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        if (w_accept && w_last) begin
          w_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_next = ST_START;
      end
      ST_START: begin
        ntt_start = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        // A coincident cfg_start is dropped: IDLE only sees it next cycle.
        if (ntt_done) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign bank_we      = r_we;
  assign bank_addr    = r_addr;
  assign bank_wdata   = r_wdata;
  assign ntt_kd_mode  = r_mode;
  assign reduced_flag = r_red;

endmodule

// File: tb/tb_kd_poly_loader.sv
module tb_kd_poly_loader;

  localparam int KQ_M = 3329;
  localparam int DQ_M = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_kd_mode = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = 24'd0;
  logic [3:0]  bank_we;
  logic [6:0]  bank_addr;
  logic [23:0] bank_wdata;
  logic        ntt_start;
  logic        ntt_kd_mode;
  logic        ntt_done = 1'b0;
  logic        busy;
  logic        reduced_flag;

  kd_poly_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_kd_mode  (cfg_kd_mode),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .bank_we      (bank_we),
    .bank_addr    (bank_addr),
    .bank_wdata   (bank_wdata),
    .ntt_start    (ntt_start),
    .ntt_kd_mode  (ntt_kd_mode),
    .ntt_done     (ntt_done),
    .busy         (busy),
    .reduced_flag (reduced_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bank;
    logic [6:0]  addr;
    logic [23:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          n_starts = 0;
  logic [23:0] pat[256];
  int          gap_pct = 0;
  int          inj_cfg_k = -1;
  int          inj_done_k = -1;
  bit          wait_cfg_test = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: coefficient reduced into [0, q) by plain modulo.
  function automatic logic [23:0] model_word(input bit mode, input logic [23:0] d);
    int lo, hi, c;
    if (!mode) begin
      lo = int'(d[11:0]) % KQ_M;
      hi = int'(d[23:12]) % KQ_M;
      return {12'(hi), 12'(lo)};
    end
    c = int'(d[22:0]) % DQ_M;
    return 24'(c);
  endfunction

  function automatic bit model_reduces(input bit mode, input logic [23:0] d);
    logic [23:0] raw;
    raw = mode ? {1'b0, d[22:0]} : d;
    return model_word(mode, d) != raw;
  endfunction

  // Monitor: every bank write must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bank_we != 4'b0000) begin
        n_writes++;
        if (sb.size() == 0) begin
          chk("unexpected_write", {28'd0, bank_we}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("bank_we", {28'd0, bank_we}, 32'(4'b0001 << e.bank));
          chk("bank_addr", {25'd0, bank_addr}, {25'd0, e.addr});
          chk("bank_wdata", {8'd0, bank_wdata}, {8'd0, e.data});
        end
      end
      if (ntt_start) n_starts++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_bank_we"}, {28'd0, bank_we}, 32'd0);
    chk({tag, "_bank_addr"}, {25'd0, bank_addr}, 32'd0);
    chk({tag, "_bank_wdata"}, {8'd0, bank_wdata}, 32'd0);
    chk({tag, "_ntt_start"}, {31'd0, ntt_start}, 32'd0);
    chk({tag, "_ntt_kd_mode"}, {31'd0, ntt_kd_mode}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_reduced_flag"}, {31'd0, reduced_flag}, 32'd0);
  endtask

  task automatic do_load(input bit mode, input bit abort_at_50);
    int n = mode ? 256 : 128;
    bit exp_flag = 1'b0;
    int w0 = n_writes;
    int s0 = n_starts;
    int waitc;

    @(negedge clk);
    cfg_start   = 1'b1;
    cfg_kd_mode = mode;
    @(negedge clk);
    cfg_start   = 1'b0;
    cfg_kd_mode = 1'($urandom_range(0, 1));
    chk("s_ready_after_cfg", {31'd0, s_ready}, 32'd1);
    chk("busy_after_cfg", {31'd0, busy}, 32'd1);
    chk("flag_cleared", {31'd0, reduced_flag}, 32'd0);

    for (int k = 0; k < n; k++) begin
      if (abort_at_50 && k == 50) begin
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        repeat (3) @(negedge clk);
        check_outputs_zero("rst_held");
        chk("rst_no_start", 32'(n_starts - s0), 32'd0);
        chk("rst_sb_empty", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        return;
      end
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 24'($urandom);
        @(negedge clk);
      end
      if (k == inj_cfg_k) begin
        s_valid     = 1'b0;
        cfg_start   = 1'b1;
        cfg_kd_mode = ~mode;
        @(negedge clk);
        cfg_start   = 1'b0;
        chk("mode_after_cfg_in_load", {31'd0, ntt_kd_mode}, {31'd0, mode});
      end
      if (k == inj_done_k) begin
        s_valid  = 1'b0;
        ntt_done = 1'b1;
        @(negedge clk);
        ntt_done = 1'b0;
        chk("busy_after_done_in_load", {31'd0, busy}, 32'd1);
      end
      waitc = 0;
      while (!s_ready && waitc < 16) begin
        s_valid = 1'b0;
        @(negedge clk);
        waitc++;
      end
      if (!s_ready) begin
        chk("s_ready_in_load", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
      s_valid = 1'b1;
      s_data  = pat[k];
      sb.push_back('{bank: 2'(k % 4), addr: 7'(k / 4), data: model_word(mode, pat[k])});
      exp_flag = exp_flag | model_reduces(mode, pat[k]);
      @(negedge clk);
      chk("reduced_flag", {31'd0, reduced_flag}, {31'd0, exp_flag});
      chk("ntt_kd_mode", {31'd0, ntt_kd_mode}, {31'd0, mode});
    end
    s_valid = 1'b0;

    chk("s_ready_after_last", {31'd0, s_ready}, 32'd0);
    chk("start_in_flush", {31'd0, ntt_start}, 32'd0);
    @(negedge clk);
    chk("ntt_start_pulse", {31'd0, ntt_start}, 32'd1);
    @(negedge clk);
    chk("ntt_start_single", {31'd0, ntt_start}, 32'd0);
    chk("busy_in_wait", {31'd0, busy}, 32'd1);
    repeat ($urandom_range(1, 4)) @(negedge clk);

    if (wait_cfg_test) begin
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("busy_cfg_in_wait", {31'd0, busy}, 32'd1);
      chk("s_ready_cfg_in_wait", {31'd0, s_ready}, 32'd0);
      cfg_start = 1'b1;
      ntt_done  = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      ntt_done  = 1'b0;
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("cfg_dropped_busy", {31'd0, busy}, 32'd0);
      chk("cfg_dropped_ready", {31'd0, s_ready}, 32'd0);
    end else begin
      ntt_done = 1'b1;
      @(negedge clk);
      ntt_done = 1'b0;
      chk("busy_after_done", {31'd0, busy}, 32'd0);
    end

    chk("write_count", 32'(n_writes - w0), 32'(n));
    chk("start_count", 32'(n_starts - s0), 32'd1);
    chk("final_flag", {31'd0, reduced_flag}, {31'd0, exp_flag});
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // Kyber, {k+1, k}: nothing needs reduction.
    for (int k = 0; k < 256; k++) pat[k] = {12'(k + 1), 12'(k)};
    gap_pct = 0;
    do_load(1'b0, 1'b0);

    // Dilithium, s_data = k.
    for (int k = 0; k < 256; k++) pat[k] = 24'(k);
    do_load(1'b1, 1'b0);

    // Kyber with boundary word after a few in-range words.
    for (int k = 0; k < 256; k++) begin
      if (k < 5) pat[k] = {12'($urandom_range(0, KQ_M - 1)), 12'($urandom_range(0, KQ_M - 1))};
      else       pat[k] = 24'($urandom);
    end
    pat[5] = {12'd4095, 12'd3329};
    pat[6] = {12'd3328, 12'd3329};
    gap_pct = 20;
    do_load(1'b0, 1'b0);

    // Dilithium boundaries; bit 23 randomised to show it is ignored.
    for (int k = 0; k < 256; k++) begin
      if (k < 10) pat[k] = {1'($urandom_range(0, 1)), 23'($urandom_range(0, DQ_M - 1))};
      else        pat[k] = 24'($urandom);
    end
    pat[10] = 24'd8380417;
    pat[11] = 24'd8388607;
    pat[12] = 24'd8380416;
    pat[13] = 24'h800000 | 24'd8380416;
    gap_pct = 10;
    do_load(1'b1, 1'b0);

    // Heavy back-pressure plus ignored cfg_start / ntt_done.
    for (int k = 0; k < 256; k++) pat[k] = 24'($urandom);
    gap_pct       = 50;
    inj_cfg_k     = 30;
    inj_done_k    = 60;
    wait_cfg_test = 1'b1;
    do_load(1'b0, 1'b0);
    inj_cfg_k     = -1;
    inj_done_k    = -1;
    wait_cfg_test = 1'b0;

    // Reset after 50 accepted words, then a full load from k = 0.
    gap_pct = 0;
    do_load(1'b0, 1'b1);
    for (int k = 0; k < 256; k++) pat[k] = 24'($urandom);
    gap_pct = 10;
    do_load(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
